udp_rx: RTL and testbench
=========================

UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 The module SHALL have parameter LISTEN_PORT, default 16'd8080, the destination port accepted when port filtering is compiled in.
REQ-002 The module SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port ip_rx_start  input  1  one-cycle pulse marking that the IP header fields are valid.
REQ-005 The module SHALL have port ip_rx_protocol  input  8  IP protocol number; UDP is 8'd17.
REQ-006 The module SHALL have port ip_rx_src_ip  input  32  source IPv4 address.
REQ-007 The module SHALL have port ip_rx_is_valid  input  1  IP layer header check passed.
REQ-008 The module SHALL have port ip_rx_data_in  input  8  IP payload byte.
REQ-009 The module SHALL have port ip_rx_data_in_valid  input  1  data_in qualifier.
REQ-010 The module SHALL have port ip_rx_data_in_last  input  1  last IP payload byte; valid only with data_in_valid.
REQ-011 The module SHALL have port udp_rx_start  output  1  one-cycle pulse marking that the UDP header outputs are valid.
REQ-012 The module SHALL have port udp_rx_hdr_is_valid  output  1  UDP header accepted.
REQ-013 The module SHALL have port udp_rx_src_ip  output  32  latched source IP.
REQ-014 The module SHALL have port udp_rx_src_port  output  16  source port.
REQ-015 The module SHALL have port udp_rx_dst_port  output  16  destination port.
REQ-016 The module SHALL have port udp_rx_data_length  output  16  payload bytes, equal to the length field minus 8.
REQ-017 The module SHALL have port udp_rx_data_out  output  8  payload byte.
REQ-018 The module SHALL have port udp_rx_data_out_valid  output  1  data_out qualifier.
REQ-019 The module SHALL have port udp_rx_data_out_last  output  1  final payload byte.

Function
REQ-020 The FSM SHALL have states IDLE, HDR, DATA and DISCARD; reset state is IDLE.
REQ-021 In IDLE, on ip_rx_start with ip_rx_protocol==17 and ip_rx_is_valid==1, the FSM SHALL latch src_ip, clear the byte counter and go to HDR; otherwise it SHALL go to DISCARD on ip_rx_start.
REQ-022 In HDR, the module SHALL capture 8 valid bytes big-endian: bytes 0-1 src_port, 2-3 dst_port, 4-5 length, 6-7 checksum (checksum ignored); the counter SHALL advance only on data_in_valid.
REQ-023 On the 8th header byte, if length<8 the FSM SHALL go to DISCARD with no start pulse; otherwise udp_rx_start and udp_rx_hdr_is_valid SHALL assert on the next cycle with all header outputs stable.
REQ-024 On the 8th header byte, if length==8 the FSM SHALL emit the start pulse, produce no data beats, and go to IDLE if ip_rx_data_in_last is set, else to DISCARD.
REQ-025 If ip_rx_data_in_last occurs before the 8th header byte, the FSM SHALL abort to IDLE with no start pulse and no data beats.
REQ-026 In DATA, each valid input byte SHALL appear on udp_rx_data_out with data_out_valid one cycle later (1-cycle registered latency, no bubbles added).
REQ-027 udp_rx_data_out_last SHALL assert with the byte at which the payload count reaches data_length, or with an input byte carrying data_in_last, whichever comes first.
REQ-028 After the payload count reaches data_length, remaining input bytes (e.g. Ethernet padding) SHALL be dropped in DISCARD until data_in_last, then the FSM SHALL return to IDLE.
REQ-029 In DISCARD, outputs SHALL stay idle and the FSM SHALL return to IDLE on a valid byte carrying data_in_last.
REQ-030 Any ip_rx_start received outside IDLE SHALL be ignored.
REQ-031 The payload counter SHALL be 16 bits, compare with ==, and never wrap within a frame.
REQ-032 udp_rx_hdr_is_valid and the header outputs SHALL hold until the next accepted header.

Reset
REQ-033 Asserting reset (low) at any time, including mid-frame, SHALL immediately force IDLE and zero all outputs and counters; the first frame after deassertion SHALL require a new ip_rx_start.

Configuration
REQ-034 With UDP_RX_PORT_FILTER_EN defined, a header whose dst_port differs from LISTEN_PORT SHALL go to DISCARD with no start pulse; without the macro, all ports SHALL be accepted.

Verification
REQ-035 The bench SHALL cover: proto 17, header 1F90/1F90/000C/0000, payload AA BB CC DD with last -> start pulse, length 4, four beats AA..DD, last on DD.
REQ-036 The bench SHALL cover: proto 6 frame -> no start, no data; next valid UDP frame is received correctly.
REQ-037 The bench SHALL cover: length 0x000A with 6 payload bytes -> 2 beats, last on the 2nd, 4 padding bytes dropped.
REQ-038 The bench SHALL cover: data_in_last on header byte 5 -> no start; length 0x0008 -> start, data_length 0, no beats.
REQ-039 The bench SHALL cover: reset pulse mid-payload -> outputs zero that cycle; the following frame is received intact.
REQ-040 The bench SHALL cover, with UDP_RX_PORT_FILTER_EN: dst_port 0x0035 -> dropped; dst_port 0x1F90 -> received.

Source files
------------

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - UDP receive header parser and payload forwarder
//
// Parses the 8-byte UDP header that follows an accepted IP header, publishes
// the header fields with a one-cycle udp_rx_start pulse, then forwards the
// payload bytes with one cycle of latency. Trailing bytes beyond the UDP
// length (Ethernet padding) and rejected frames are swallowed up to data_in_last.
//
// Optional build macro: UDP_RX_PORT_FILTER_EN - accept only dst_port == LISTEN_PORT.
//
// Ports:
//   clk                   sole clock, rising edge
//   reset                 asynchronous active-low reset
//   ip_rx_start           pulse: IP header fields valid
//   ip_rx_protocol        IP protocol number (UDP = 17)
//   ip_rx_src_ip          source IPv4 address
//   ip_rx_is_valid        IP header check passed
//   ip_rx_data_in*        IP payload byte stream (data, valid, last)
//   udp_rx_start          pulse: UDP header outputs valid
//   udp_rx_hdr_is_valid   a header has been accepted (held)
//   udp_rx_src_ip         latched source IP
//   udp_rx_src_port       UDP source port
//   udp_rx_dst_port       UDP destination port
//   udp_rx_data_length    payload length (length field - 8)
//   udp_rx_data_out*      payload byte stream (data, valid, last)

module udp_rx #(
    parameter logic [15:0] LISTEN_PORT = 16'd8080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_rx_start,
    input  logic [7:0]  ip_rx_protocol,
    input  logic [31:0] ip_rx_src_ip,
    input  logic        ip_rx_is_valid,
    input  logic [7:0]  ip_rx_data_in,
    input  logic        ip_rx_data_in_valid,
    input  logic        ip_rx_data_in_last,
    output logic        udp_rx_start,
    output logic        udp_rx_hdr_is_valid,
    output logic [31:0] udp_rx_src_ip,
    output logic [15:0] udp_rx_src_port,
    output logic [15:0] udp_rx_dst_port,
    output logic [15:0] udp_rx_data_length,
    output logic [7:0]  udp_rx_data_out,
    output logic        udp_rx_data_out_valid,
    output logic        udp_rx_data_out_last
);

`ifdef UDP_RX_PORT_FILTER_EN
    localparam logic FILTER_EN = 1'b1;
`else
    localparam logic FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HDR, DATA, DISCARD} state_t;

    state_t      state;
    logic [2:0]  hdr_cnt;
    logic [47:0] hdr_sr;     // header bytes 0..5; checksum bytes are never stored
    logic [31:0] src_ip_q;
    logic [15:0] pay_cnt;

    logic [15:0] f_src_port;
    logic [15:0] f_dst_port;
    logic [15:0] f_length;
    logic        port_ok;
    logic [15:0] pay_next;
    logic        pay_done;

    assign f_src_port = hdr_sr[47:32];
    assign f_dst_port = hdr_sr[31:16];
    assign f_length   = hdr_sr[15:0];
    assign port_ok    = !FILTER_EN || (f_dst_port == LISTEN_PORT);
    assign pay_next   = pay_cnt + 16'd1;
    assign pay_done   = (pay_next == udp_rx_data_length);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            hdr_cnt               <= 3'd0;
            hdr_sr                <= 48'd0;
            src_ip_q              <= 32'd0;
            pay_cnt               <= 16'd0;
            udp_rx_start          <= 1'b0;
            udp_rx_hdr_is_valid   <= 1'b0;
            udp_rx_src_ip         <= 32'd0;
            udp_rx_src_port       <= 16'd0;
            udp_rx_dst_port       <= 16'd0;
            udp_rx_data_length    <= 16'd0;
            udp_rx_data_out       <= 8'd0;
            udp_rx_data_out_valid <= 1'b0;
            udp_rx_data_out_last  <= 1'b0;
        end else begin
            udp_rx_start          <= 1'b0;
            udp_rx_data_out_valid <= 1'b0;
            udp_rx_data_out_last  <= 1'b0;

            case (state)
                IDLE: begin
                    if (ip_rx_start) begin
                        if (ip_rx_protocol == 8'd17 && ip_rx_is_valid) begin
                            src_ip_q <= ip_rx_src_ip;
                            hdr_cnt  <= 3'd0;
                            state    <= HDR;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                end

                HDR: begin
                    if (ip_rx_data_in_valid) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt < 3'd6)
                            hdr_sr <= {hdr_sr[39:0], ip_rx_data_in};
                        if (hdr_cnt == 3'd7) begin
                            if (f_length < 16'd8 || !port_ok) begin
                                // Rejected; a frame already ending here needs no discard phase
                                state <= ip_rx_data_in_last ? IDLE : DISCARD;
                            end else begin
                                udp_rx_start        <= 1'b1;
                                udp_rx_hdr_is_valid <= 1'b1;
                                udp_rx_src_ip       <= src_ip_q;
                                udp_rx_src_port     <= f_src_port;
                                udp_rx_dst_port     <= f_dst_port;
                                udp_rx_data_length  <= f_length - 16'd8;
                                pay_cnt             <= 16'd0;
                                if (ip_rx_data_in_last)
                                    state <= IDLE;
                                else if (f_length == 16'd8)
                                    state <= DISCARD;
                                else
                                    state <= DATA;
                            end
                        end else if (ip_rx_data_in_last) begin
                            state <= IDLE;   // truncated header
                        end
                    end
                end

                DATA: begin
                    if (ip_rx_data_in_valid) begin
                        udp_rx_data_out       <= ip_rx_data_in;
                        udp_rx_data_out_valid <= 1'b1;
                        udp_rx_data_out_last  <= pay_done || ip_rx_data_in_last;
                        pay_cnt               <= pay_next;
                        if (ip_rx_data_in_last)
                            state <= IDLE;
                        else if (pay_done)
                            state <= DISCARD;
                    end
                end

                DISCARD: begin
                    if (ip_rx_data_in_valid && ip_rx_data_in_last)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// tb/tb_udp_rx.sv - scoreboard testbench for udp_rx
module tb_udp_rx;

    localparam logic [15:0] LP = 16'h1F90;

    logic        clk = 1'b0;
    logic        reset;
    logic        ip_rx_start;
    logic [7:0]  ip_rx_protocol;
    logic [31:0] ip_rx_src_ip;
    logic        ip_rx_is_valid;
    logic [7:0]  ip_rx_data_in;
    logic        ip_rx_data_in_valid;
    logic        ip_rx_data_in_last;
    logic        udp_rx_start;
    logic        udp_rx_hdr_is_valid;
    logic [31:0] udp_rx_src_ip;
    logic [15:0] udp_rx_src_port;
    logic [15:0] udp_rx_dst_port;
    logic [15:0] udp_rx_data_length;
    logic [7:0]  udp_rx_data_out;
    logic        udp_rx_data_out_valid;
    logic        udp_rx_data_out_last;

    always #5 clk = ~clk;

    udp_rx #(.LISTEN_PORT(LP)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ip_rx_start           (ip_rx_start),
        .ip_rx_protocol        (ip_rx_protocol),
        .ip_rx_src_ip          (ip_rx_src_ip),
        .ip_rx_is_valid        (ip_rx_is_valid),
        .ip_rx_data_in         (ip_rx_data_in),
        .ip_rx_data_in_valid   (ip_rx_data_in_valid),
        .ip_rx_data_in_last    (ip_rx_data_in_last),
        .udp_rx_start          (udp_rx_start),
        .udp_rx_hdr_is_valid   (udp_rx_hdr_is_valid),
        .udp_rx_src_ip         (udp_rx_src_ip),
        .udp_rx_src_port       (udp_rx_src_port),
        .udp_rx_dst_port       (udp_rx_dst_port),
        .udp_rx_data_length    (udp_rx_data_length),
        .udp_rx_data_out       (udp_rx_data_out),
        .udp_rx_data_out_valid (udp_rx_data_out_valid),
        .udp_rx_data_out_last  (udp_rx_data_out_last)
    );

    int tests = 0;
    int fails = 0;

    logic [79:0] exp_hdr[$];   // {src_ip, src_port, dst_port, data_length}
    logic [8:0]  exp_dat[$];   // {byte, last}
    logic [7:0]  fb[$];        // frame bytes handed to model and driver

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what a UDP receiver should emit for the frame in fb
    task automatic model(input logic [7:0] proto, input logic isv, input logic [31:0] sip);
        int n;
        int plen;
        int beats;
        logic [15:0] sp, dp, len;
        n = fb.size();
        if (proto != 8'd17 || !isv) return;
        if (n < 8) return;
        sp  = {fb[0], fb[1]};
        dp  = {fb[2], fb[3]};
        len = {fb[4], fb[5]};
        if (len < 16'd8) return;
`ifdef UDP_RX_PORT_FILTER_EN
        if (dp != LP) return;
`endif
        exp_hdr.push_back({sip, sp, dp, len - 16'd8});
        plen  = int'(len) - 8;
        beats = (n - 8 < plen) ? n - 8 : plen;
        for (int i = 0; i < beats; i++)
            exp_dat.push_back({fb[8 + i], (i == beats - 1)});
    endtask

    task automatic drive_frame(input logic [7:0] proto, input logic isv, input logic [31:0] sip,
                               input logic gaps, input int extra_start_idx, input logic send_last);
        int n;
        n = fb.size();
        @(posedge clk); #1;
        ip_rx_start    = 1'b1;
        ip_rx_protocol = proto;
        ip_rx_src_ip   = sip;
        ip_rx_is_valid = isv;
        @(posedge clk); #1;
        ip_rx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            ip_rx_data_in       = fb[i];
            ip_rx_data_in_valid = 1'b1;
            ip_rx_data_in_last  = send_last && (i == n - 1);
            if (i == extra_start_idx) begin
                ip_rx_start    = 1'b1;
                ip_rx_protocol = 8'd17;
                ip_rx_is_valid = 1'b1;
                ip_rx_src_ip   = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            ip_rx_data_in_valid = 1'b0;
            ip_rx_data_in_last  = 1'b0;
            ip_rx_start         = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] proto, input logic isv, input logic [31:0] sip,
                             input logic gaps, input int extra_start_idx);
        model(proto, isv, sip);
        drive_frame(proto, isv, sip, gaps, extra_start_idx, 1'b1);
    endtask

    task automatic set_hdr(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
        fb.delete();
        fb.push_back(sp[15:8]);  fb.push_back(sp[7:0]);
        fb.push_back(dp[15:8]);  fb.push_back(dp[7:0]);
        fb.push_back(len[15:8]); fb.push_back(len[7:0]);
        fb.push_back(8'h00);     fb.push_back(8'h00);
    endtask

    // Monitor: compare every DUT output event against the scoreboard queues
    always @(negedge clk) begin
        if (reset) begin
            if (udp_rx_start) begin
                if (exp_hdr.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    check("hdr_fields",
                          {udp_rx_src_ip, udp_rx_src_port, udp_rx_dst_port, udp_rx_data_length},
                          exp_hdr.pop_front());
                    check("hdr_is_valid", udp_rx_hdr_is_valid, 1);
                end
            end
            if (udp_rx_data_out_valid) begin
                if (exp_dat.size() == 0)
                    check("unexpected_beat", {udp_rx_data_out, udp_rx_data_out_last}, 0);
                else
                    check("data_beat", {udp_rx_data_out, udp_rx_data_out_last}, exp_dat.pop_front());
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  proto;
        logic        isv;
        logic [31:0] sip;
        logic [15:0] len;
        int          plen;
        int          n;

        reset = 1'b0;
        ip_rx_start = 1'b0; ip_rx_protocol = 8'd0; ip_rx_src_ip = 32'd0; ip_rx_is_valid = 1'b0;
        ip_rx_data_in = 8'd0; ip_rx_data_in_valid = 1'b0; ip_rx_data_in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {udp_rx_start, udp_rx_hdr_is_valid, udp_rx_src_ip, udp_rx_src_port, udp_rx_dst_port,
               udp_rx_data_length, udp_rx_data_out, udp_rx_data_out_valid, udp_rx_data_out_last}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic frame: length 12, payload AA BB CC DD
        set_hdr(16'h1F90, 16'h1F90, 16'h000C);
        fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC); fb.push_back(8'hDD);
        run_frame(8'd17, 1'b1, 32'hC0A8_0001, 1'b0, -1);
        check("hdr_is_valid_held", udp_rx_hdr_is_valid, 1);

        // Non-UDP protocol dropped, then a good frame
        run_frame(8'd6, 1'b1, 32'h0A00_0001, 1'b0, -1);
        set_hdr(16'h1234, 16'h1F90, 16'h000B);
        fb.push_back(8'h01); fb.push_back(8'h02); fb.push_back(8'h03);
        run_frame(8'd17, 1'b1, 32'h0A00_0002, 1'b1, -1);

        // Length 10 with 6 payload bytes: 2 beats, padding dropped
        set_hdr(16'h0400, 16'h1F90, 16'h000A);
        for (int i = 0; i < 6; i++) fb.push_back(8'h50 + 8'(i));
        run_frame(8'd17, 1'b1, 32'h0A00_0003, 1'b0, -1);

        // Truncated header (last on byte 5), then zero-length datagrams
        set_hdr(16'h0001, 16'h1F90, 16'h0010);
        while (fb.size() > 5) void'(fb.pop_back());
        run_frame(8'd17, 1'b1, 32'h0A00_0004, 1'b0, -1);
        set_hdr(16'h0002, 16'h1F90, 16'h0008);
        run_frame(8'd17, 1'b1, 32'h0A00_0005, 1'b0, -1);
        set_hdr(16'h0003, 16'h1F90, 16'h0008);
        fb.push_back(8'hEE); fb.push_back(8'hEF);
        run_frame(8'd17, 1'b1, 32'h0A00_0006, 1'b0, -1);
        check("data_length_zero", udp_rx_data_length, 0);

        // Port filtering (effective only when compiled in)
        set_hdr(16'h0004, 16'h0035, 16'h000A);
        fb.push_back(8'h11); fb.push_back(8'h22);
        run_frame(8'd17, 1'b1, 32'h0A00_0007, 1'b0, -1);
        set_hdr(16'h0005, 16'h1F90, 16'h000A);
        fb.push_back(8'h33); fb.push_back(8'h44);
        run_frame(8'd17, 1'b1, 32'h0A00_0008, 1'b0, -1);

        // ip_rx_start while busy is ignored (header and payload phase)
        set_hdr(16'h0006, 16'h1F90, 16'h000E);
        for (int i = 0; i < 6; i++) fb.push_back(8'h70 + 8'(i));
        run_frame(8'd17, 1'b1, 32'h0A00_0009, 1'b0, 3);
        set_hdr(16'h0007, 16'h1F90, 16'h000E);
        for (int i = 0; i < 6; i++) fb.push_back(8'h80 + 8'(i));
        run_frame(8'd17, 1'b1, 32'h0A00_000A, 1'b0, 10);

        // Reset mid-payload: two of four payload bytes delivered, then reset
        set_hdr(16'h0008, 16'h1F90, 16'h000C);
        fb.push_back(8'h91); fb.push_back(8'h92);
        exp_hdr.push_back({32'h0A00_000B, 16'h0008, 16'h1F90, 16'h0004});
        exp_dat.push_back({8'h91, 1'b0});
        exp_dat.push_back({8'h92, 1'b0});
        drive_frame(8'd17, 1'b1, 32'h0A00_000B, 1'b0, -1, 1'b0);
        check("hdr_valid_before_reset", udp_rx_hdr_is_valid, 1);
        reset = 1'b0;
        #1;
        check("reset_midframe_outputs",
              {udp_rx_start, udp_rx_hdr_is_valid, udp_rx_src_ip, udp_rx_src_port, udp_rx_dst_port,
               udp_rx_data_length, udp_rx_data_out, udp_rx_data_out_valid, udp_rx_data_out_last}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        set_hdr(16'h0009, 16'h1F90, 16'h000B);
        fb.push_back(8'hA1); fb.push_back(8'hA2); fb.push_back(8'hA3);
        run_frame(8'd17, 1'b1, 32'h0A00_000C, 1'b0, -1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            proto = ($urandom_range(0, 5) == 0) ? 8'd6 : 8'd17;
            isv   = ($urandom_range(0, 7) != 0);
            sip   = $urandom;
            if ($urandom_range(0, 9) == 0) len = 16'($urandom_range(0, 7));
            else                           len = 16'(8 + $urandom_range(0, 12));
            plen = (len >= 16'd8) ? int'(len) - 8 : 0;
            set_hdr(16'($urandom), ($urandom_range(0, 1) == 1) ? LP : 16'($urandom), len);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(1, 7);
            else                           n = 8 + $urandom_range(0, plen + 4);
            while (fb.size() > n) void'(fb.pop_back());
            while (fb.size() < n) fb.push_back(8'($urandom));
            run_frame(proto, isv, sip, 1'($urandom_range(0, 1)), -1);
        end

        for (int i = 0; i < 50 && (exp_hdr.size() != 0 || exp_dat.size() != 0); i++)
            @(posedge clk);
        #1;
        check("hdr_queue_drained", exp_hdr.size(), 0);
        check("data_queue_drained", exp_dat.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
